spi_xfer_seq: RTL and testbench
===============================

Name: spi_xfer_seq

Overview:
Frame sequencer that sits between the SPI TX/RX synchronous FIFOs and the SPI shift engine. It pops TX frames, launches the shift engine one frame at a time, and pushes the received frames into the RX FIFO. It also counts frames per command, handles RX back-pressure, and flushes the FIFOs on abort.

Parameters:
CFG_FRAME_SIZE, 8, frame width in bits (4-32)
CFG_CNT_WIDTH, 16, width of the frame-count register

Ports:
pclk  input  1  system clock, all logic on rising edge
aresetn  input  1  asynchronous active-low reset
sresetn  input  1  synchronous active-low reset, same effect as aresetn
cmd_go  input  1  1-cycle pulse; loads frame count and starts a command
cmd_abort  input  1  1-cycle pulse; terminates the current command
cfg_frames  input  CFG_CNT_WIDTH  frames per command; 0 = run until abort
cfg_rx_discard  input  1  1 = do not push received frames
tx_data  input  CFG_FRAME_SIZE  TX FIFO head data
tx_flag  input  1  TX FIFO head flag
tx_empty  input  1  TX FIFO empty
tx_read  output  1  TX FIFO pop strobe
rx_full  input  1  RX FIFO full
rx_write  output  1  RX FIFO push strobe
rx_data  output  CFG_FRAME_SIZE  frame to RX FIFO
rx_flag  output  1  flag to RX FIFO (copy of the launched TX flag)
fifo_flush  output  1  1-cycle fiforst to both FIFOs
xfer_start  output  1  1-cycle launch pulse to shift engine
xfer_txdata  output  CFG_FRAME_SIZE  frame to shift
xfer_done  input  1  1-cycle pulse; engine finished the frame
xfer_rxdata  input  CFG_FRAME_SIZE  received frame, valid with xfer_done
busy  output  1  command active
done  output  1  1-cycle pulse at normal command completion
rx_stall  output  1  high while the sequencer waits on rx_full
frames_left  output  CFG_CNT_WIDTH  remaining frame count

Behaviour:
- Reset (aresetn low asynchronously, or sresetn low at the clock edge): state IDLE; all strobes 0; busy, done and rx_stall 0; frames_left 0; the data hold registers are 0.
- States: IDLE, ACTIVE, START, WAIT, PUSH, ABORTW.
- IDLE: on cmd_go, frames_left <= cfg_frames, busy <= 1, next state ACTIVE. cmd_abort in IDLE is ignored.
- ACTIVE: when tx_empty=0:
  - tx_read=1 combinationally for that cycle.
  - tx_data and tx_flag are latched into the hold registers.
  - next state START.
  - While tx_empty=1 the sequencer waits in ACTIVE; this is not an error.
- START: xfer_start=1 for exactly 1 cycle with xfer_txdata=hold. Next state WAIT. xfer_start therefore follows tx_read by exactly 1 cycle.
- WAIT: on xfer_done, latch xfer_rxdata into rx_data. Next state PUSH.
- PUSH:
  - If cfg_rx_discard=1, no write.
  - Else if rx_full=0: rx_write=1 for 1 cycle.
  - Else: stay in PUSH with rx_stall=1, retrying each cycle. A frame is never dropped.
  - On leaving PUSH, if cfg_frames≠0, frames_left decrements.
  - If the decremented value is 0: done=1 for 1 cycle, busy <= 0, next state IDLE. Otherwise next state ACTIVE.
  - With cfg_frames=0, frames_left stays 0 and the command runs until abort.
- Abort:
  - From ACTIVE: go to IDLE immediately.
  - From START or WAIT: go to ABORTW, which holds until xfer_done. The received frame is dropped.
  - From PUSH: drop the frame and go to IDLE.
  - On entering IDLE via abort: fifo_flush=1 for 1 cycle, busy <= 0, frames_left <= 0, no done pulse.
  - cmd_abort coincident with cmd_go in IDLE: cmd_go wins.
- cmd_go while busy is ignored.
- The frame count never underflows or wraps.

Decomposition:
- Package spi_seq_pkg holds the state encoding (localparam enum, 3 bits) and the default frame-width constants, shared with the shift engine.
- No sub-module: one FSM plus the frame counter and the hold registers in a single module.

Test Plan:
1. cfg_frames=3, TX preloaded 0xA1,0xB2,0xC3, engine loops back after 4 cycles, cmd_go → three tx_read/xfer_start pairs 1 cycle apart, RX gets 0xA1,0xB2,0xC3, done pulses once, busy falls, frames_left=0.
2. cfg_frames=2, TX empty at go, push 0x55 after 10 cycles → no xfer_start before tx_read; xfer_start exactly 1 cycle after tx_read.
3. rx_full=1 for 5 cycles at the first PUSH → rx_stall high 5 cycles, no rx_write, then a single rx_write with the correct data; no frame lost.
4. cmd_abort while in WAIT, xfer_done 3 cycles later → no rx_write, fifo_flush pulses 1 cycle after xfer_done, busy=0, no done pulse.
5. cfg_frames=0, cfg_rx_discard=1, 6 TX frames then abort → 6 xfer_start, 0 rx_write, busy held until abort.
6. aresetn asserted mid-WAIT → all outputs reset immediately; a new cmd_go after release runs a clean 1-frame transfer.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared SPI sequencer definitions: FSM state encoding and default frame geometry.
// Also used by the shift engine so both sides agree on frame width.
package spi_seq_pkg;

   localparam int SPI_FRAME_SIZE_DEF = 8;
   localparam int SPI_CNT_WIDTH_DEF  = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACTIVE = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_PUSH   = 3'd4,
      ST_ABORTW = 3'd5
   } seq_state_t;

endpackage

// File: rtl/spi_xfer_seq.sv
// Frame sequencer: TX FIFO pop -> shift engine launch (1 cycle later) -> RX FIFO push.
// Stalls in PUSH while rx_full (frames never dropped); waits in ACTIVE while tx_empty.
module spi_xfer_seq
   import spi_seq_pkg::*;
#(
   parameter int CFG_FRAME_SIZE = SPI_FRAME_SIZE_DEF,
   parameter int CFG_CNT_WIDTH  = SPI_CNT_WIDTH_DEF
) (
   input  logic                      pclk,
   input  logic                      aresetn,
   input  logic                      sresetn,
   input  logic                      cmd_go,
   input  logic                      cmd_abort,
   input  logic [CFG_CNT_WIDTH-1:0]  cfg_frames,
   input  logic                      cfg_rx_discard,
   input  logic [CFG_FRAME_SIZE-1:0] tx_data,
   input  logic                      tx_flag,
   input  logic                      tx_empty,
   output logic                      tx_read,
   input  logic                      rx_full,
   output logic                      rx_write,
   output logic [CFG_FRAME_SIZE-1:0] rx_data,
   output logic                      rx_flag,
   output logic                      fifo_flush,
   output logic                      xfer_start,
   output logic [CFG_FRAME_SIZE-1:0] xfer_txdata,
   input  logic                      xfer_done,
   input  logic [CFG_FRAME_SIZE-1:0] xfer_rxdata,
   output logic                      busy,
   output logic                      done,
   output logic                      rx_stall,
   output logic [CFG_CNT_WIDTH-1:0]  frames_left
);

   seq_state_t state, state_nxt;

   logic                      run_forever;
   logic [CFG_FRAME_SIZE-1:0] tx_hold;
   logic                      flag_hold;
   logic [CFG_FRAME_SIZE-1:0] rx_hold;

   logic load_cmd;
   logic latch_tx;
   logic latch_rx;
   logic cnt_step;
   logic end_ok;
   logic end_abort;
   logic last_frame;

   // frames_left <= 1 rather than == 1 so a zero count can never wrap.
   assign last_frame = !run_forever && (frames_left <= CFG_CNT_WIDTH'(1));

   assign xfer_txdata = tx_hold;
   assign rx_flag     = flag_hold;
   assign rx_data     = rx_hold;

   always_comb begin
      state_nxt  = state;
      tx_read    = 1'b0;
      xfer_start = 1'b0;
      rx_write   = 1'b0;
      rx_stall   = 1'b0;
      load_cmd   = 1'b0;
      latch_tx   = 1'b0;
      latch_rx   = 1'b0;
      cnt_step   = 1'b0;
      end_ok     = 1'b0;
      end_abort  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (cmd_go) begin
               load_cmd  = 1'b1;
               state_nxt = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (cmd_abort) begin
               end_abort = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!tx_empty) begin
               tx_read   = 1'b1;
               latch_tx  = 1'b1;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            // The launch goes out even on abort; ABORTW then drains the engine.
            xfer_start = 1'b1;
            state_nxt  = cmd_abort ? ST_ABORTW : ST_WAIT;
         end
         ST_WAIT: begin
            if (cmd_abort) begin
               if (xfer_done) begin
                  end_abort = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_ABORTW;
               end
            end else if (xfer_done) begin
               latch_rx  = 1'b1;
               state_nxt = ST_PUSH;
            end
         end
         ST_PUSH: begin
            if (cmd_abort) begin
               end_abort = 1'b1;
               state_nxt = ST_IDLE;
            end else if (cfg_rx_discard || !rx_full) begin
               rx_write = !cfg_rx_discard;
               cnt_step = 1'b1;
               if (last_frame) begin
                  end_ok    = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_ACTIVE;
               end
            end else begin
               rx_stall = 1'b1;
            end
         end
         ST_ABORTW: begin
            if (xfer_done) begin
               end_abort = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         fifo_flush  <= 1'b0;
         frames_left <= '0;
         run_forever <= 1'b0;
         tx_hold     <= '0;
         flag_hold   <= 1'b0;
         rx_hold     <= '0;
      end else if (!sresetn) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         fifo_flush  <= 1'b0;
         frames_left <= '0;
         run_forever <= 1'b0;
         tx_hold     <= '0;
         flag_hold   <= 1'b0;
         rx_hold     <= '0;
      end else begin
         state      <= state_nxt;
         done       <= end_ok;
         fifo_flush <= end_abort;

         if (load_cmd) begin
            busy        <= 1'b1;
            frames_left <= cfg_frames;
            run_forever <= (cfg_frames == '0);
         end else if (end_abort) begin
            busy        <= 1'b0;
            frames_left <= '0;
         end else begin
            if (end_ok) begin
               busy <= 1'b0;
            end
            if (cnt_step && !run_forever && (frames_left != '0)) begin
               frames_left <= frames_left - CFG_CNT_WIDTH'(1);
            end
         end

         if (latch_tx) begin
            tx_hold   <= tx_data;
            flag_hold <= tx_flag;
         end
         if (latch_rx) begin
            rx_hold <= xfer_rxdata;
         end
      end
   end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: FIFO and loopback shift-engine models plus an RX scoreboard.
module tb_spi_xfer_seq;
   import spi_seq_pkg::*;

   localparam int FW = 8;
   localparam int CW = 16;

   logic          pclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          sresetn = 1'b1;
   logic          cmd_go = 1'b0;
   logic          cmd_abort = 1'b0;
   logic [CW-1:0] cfg_frames = '0;
   logic          cfg_rx_discard = 1'b0;
   logic [FW-1:0] tx_data = '0;
   logic          tx_flag = 1'b0;
   logic          tx_empty = 1'b1;
   logic          tx_read;
   logic          rx_full = 1'b0;
   logic          rx_write;
   logic [FW-1:0] rx_data;
   logic          rx_flag;
   logic          fifo_flush;
   logic          xfer_start;
   logic [FW-1:0] xfer_txdata;
   logic          xfer_done = 1'b0;
   logic [FW-1:0] xfer_rxdata = '0;
   logic          busy;
   logic          done;
   logic          rx_stall;
   logic [CW-1:0] frames_left;

   always #5 pclk = ~pclk;

   spi_xfer_seq #(.CFG_FRAME_SIZE(FW), .CFG_CNT_WIDTH(CW)) dut (
      .pclk(pclk), .aresetn(aresetn), .sresetn(sresetn),
      .cmd_go(cmd_go), .cmd_abort(cmd_abort),
      .cfg_frames(cfg_frames), .cfg_rx_discard(cfg_rx_discard),
      .tx_data(tx_data), .tx_flag(tx_flag), .tx_empty(tx_empty), .tx_read(tx_read),
      .rx_full(rx_full), .rx_write(rx_write), .rx_data(rx_data), .rx_flag(rx_flag),
      .fifo_flush(fifo_flush), .xfer_start(xfer_start), .xfer_txdata(xfer_txdata),
      .xfer_done(xfer_done), .xfer_rxdata(xfer_rxdata),
      .busy(busy), .done(done), .rx_stall(rx_stall), .frames_left(frames_left)
   );

   logic [FW:0]   tx_q[$];
   logic [FW:0]   exp_rx[$];
   logic [FW:0]   e;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            rd_cyc = -10;
   int            xd_cyc = -10;
   int            n_rd = 0, n_start = 0, n_wr = 0, n_stall = 0, n_done = 0, n_flush = 0;
   bit            flush_chk = 1'b0;
   int            eng_lat = 4;
   int            eng_cnt = 0;
   logic [FW-1:0] eng_data = '0;
   logic          s_tx_read = 1'b0, s_start = 1'b0, s_flush = 1'b0;
   logic [FW-1:0] s_txd = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor / scoreboard: samples on the falling edge.
   always @(negedge pclk) begin
      cyc++;
      s_tx_read = tx_read;
      s_start   = xfer_start;
      s_txd     = xfer_txdata;
      s_flush   = fifo_flush;
      if (tx_read) begin
         n_rd++;
         rd_cyc = cyc;
      end
      if (xfer_start) begin
         n_start++;
         chk("start_lag", 64'(cyc - rd_cyc), 64'd1);
      end
      if (xfer_done) xd_cyc = cyc;
      if (rx_stall) n_stall++;
      if (done) n_done++;
      if (fifo_flush) begin
         n_flush++;
         if (flush_chk) chk("flush_lag", 64'(cyc - xd_cyc), 64'd1);
      end
      if (rx_write) begin
         n_wr++;
         if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got 0x%0h, no frame expected", {rx_flag, rx_data});
         end else begin
            e = exp_rx.pop_front();
            chk("rx_frame", 64'({rx_flag, rx_data}), 64'(e));
         end
      end
   end

   // TX FIFO and loopback engine models, updated just after the rising edge.
   always @(posedge pclk) begin
      #1;
      if (s_flush) tx_q.delete();
      else if (s_tx_read && tx_q.size() != 0) void'(tx_q.pop_front());
      xfer_done = 1'b0;
      if (eng_cnt != 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            xfer_done   = 1'b1;
            xfer_rxdata = eng_data;
         end
      end
      if (s_start) begin
         eng_cnt  = eng_lat;
         eng_data = s_txd;
      end
      tx_empty = (tx_q.size() == 0);
      if (tx_q.size() != 0) {tx_flag, tx_data} = tx_q[0];
   end

   task automatic tick();
      @(posedge pclk);
      #2;
   endtask

   task automatic clr();
      n_rd = 0; n_start = 0; n_wr = 0; n_stall = 0; n_done = 0; n_flush = 0;
   endtask

   task automatic go(input int frames);
      cfg_frames = CW'(frames);
      cmd_go = 1'b1;
      tick();
      cmd_go = 1'b0;
   endtask

   task automatic abort_pulse();
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
   endtask

   task automatic push_tx(input logic [FW-1:0] d, input logic f, input bit expect_rx);
      tx_q.push_back({f, d});
      if (expect_rx) exp_rx.push_back({f, d});
   endtask

   task automatic wait_idle(input string nm, input int lim);
      int k;
      k = 0;
      while (busy && k < lim) begin
         tick();
         k++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s: busy still 1 after %0d cycles, expected 0", nm, lim);
      end
      tick();
      tick();
   endtask

   task automatic wait_starts(input string nm, input int n, input int lim);
      int k;
      k = 0;
      while (n_start < n && k < lim) begin
         tick();
         k++;
      end
      if (n_start < n) begin
         checks++;
         errors++;
         $display("FAIL %s: %0d starts after %0d cycles, expected %0d", nm, n_start, lim, n);
      end
   endtask

   initial begin
      int k;
      // Reset state
      repeat (3) tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_frames_left", 64'(frames_left), 64'd0);
      chk("rst_strobes", 64'({tx_read, xfer_start, rx_write, fifo_flush, done, rx_stall}), 64'd0);
      aresetn = 1'b1;
      tick();

      // 1: three frames, loopback
      clr();
      push_tx(8'hA1, 1'b0, 1'b1);
      push_tx(8'hB2, 1'b1, 1'b1);
      push_tx(8'hC3, 1'b0, 1'b1);
      go(3);
      chk("t1_busy", 64'(busy), 64'd1);
      wait_idle("t1_idle", 200);
      chk("t1_reads", 64'(n_rd), 64'd3);
      chk("t1_starts", 64'(n_start), 64'd3);
      chk("t1_writes", 64'(n_wr), 64'd3);
      chk("t1_done", 64'(n_done), 64'd1);
      chk("t1_flush", 64'(n_flush), 64'd0);
      chk("t1_frames_left", 64'(frames_left), 64'd0);
      chk("t1_pending", 64'(exp_rx.size()), 64'd0);

      // 2: TX empty at go, late frames, go while busy ignored
      clr();
      go(2);
      repeat (10) tick();
      chk("t2_no_start", 64'(n_start), 64'd0);
      chk("t2_busy", 64'(busy), 64'd1);
      cfg_frames = CW'(9);
      cmd_go = 1'b1;
      tick();
      cmd_go = 1'b0;
      cfg_frames = CW'(2);
      chk("t2_go_ignored", 64'(frames_left), 64'd2);
      push_tx(8'h55, 1'b1, 1'b1);
      wait_starts("t2_start", 1, 50);
      chk("t2_reads", 64'(n_rd), 64'd1);
      push_tx(8'h66, 1'b0, 1'b1);
      wait_idle("t2_idle", 200);
      chk("t2_starts", 64'(n_start), 64'd2);
      chk("t2_writes", 64'(n_wr), 64'd2);
      chk("t2_done", 64'(n_done), 64'd1);
      chk("t2_pending", 64'(exp_rx.size()), 64'd0);

      // 3: RX back-pressure for 5 cycles
      clr();
      rx_full = 1'b1;
      push_tx(8'h12, 1'b0, 1'b1);
      push_tx(8'h34, 1'b1, 1'b1);
      go(2);
      k = 0;
      while (!rx_stall && k < 100) begin
         tick();
         k++;
      end
      chk("t3_stall_seen", 64'(rx_stall), 64'd1);
      repeat (5) tick();
      rx_full = 1'b0;
      wait_idle("t3_idle", 200);
      chk("t3_stall_cycles", 64'(n_stall), 64'd5);
      chk("t3_writes", 64'(n_wr), 64'd2);
      chk("t3_done", 64'(n_done), 64'd1);
      chk("t3_pending", 64'(exp_rx.size()), 64'd0);

      // 4: abort in WAIT, engine finishes 3 cycles later
      clr();
      eng_lat = 3;
      flush_chk = 1'b1;
      push_tx(8'h77, 1'b1, 1'b0);
      go(2);
      wait_starts("t4_start", 1, 50);
      abort_pulse();
      wait_idle("t4_idle", 50);
      chk("t4_writes", 64'(n_wr), 64'd0);
      chk("t4_done", 64'(n_done), 64'd0);
      chk("t4_flush", 64'(n_flush), 64'd1);
      chk("t4_frames_left", 64'(frames_left), 64'd0);
      flush_chk = 1'b0;
      eng_lat = 4;

      // 5: endless command with RX discard, then abort
      clr();
      cfg_rx_discard = 1'b1;
      for (int i = 0; i < 6; i++) push_tx(FW'(8'h10 + i), i[0], 1'b0);
      go(0);
      wait_starts("t5_starts", 6, 300);
      repeat (10) tick();
      chk("t5_busy_held", 64'(busy), 64'd1);
      chk("t5_starts", 64'(n_start), 64'd6);
      chk("t5_writes", 64'(n_wr), 64'd0);
      chk("t5_frames_left", 64'(frames_left), 64'd0);
      abort_pulse();
      tick();
      chk("t5_busy_after", 64'(busy), 64'd0);
      chk("t5_flush", 64'(n_flush), 64'd1);
      chk("t5_done", 64'(n_done), 64'd0);
      cfg_rx_discard = 1'b0;

      // 6: async reset mid-WAIT, then a clean single frame
      clr();
      push_tx(8'h99, 1'b1, 1'b0);
      go(1);
      wait_starts("t6_start", 1, 50);
      tick();
      aresetn = 1'b0;
      #1;
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_frames_left", 64'(frames_left), 64'd0);
      chk("t6_rst_strobes", 64'({tx_read, xfer_start, rx_write, fifo_flush, done, rx_stall}), 64'd0);
      chk("t6_rst_hold", 64'({xfer_txdata, rx_flag, rx_data}), 64'd0);
      eng_cnt = 0;
      xfer_done = 1'b0;
      tx_q.delete();
      exp_rx.delete();
      tick();
      tick();
      aresetn = 1'b1;
      tick();
      clr();
      push_tx(8'h3C, 1'b1, 1'b1);
      go(1);
      wait_idle("t6_idle", 100);
      chk("t6_starts", 64'(n_start), 64'd1);
      chk("t6_writes", 64'(n_wr), 64'd1);
      chk("t6_done", 64'(n_done), 64'd1);
      chk("t6_pending", 64'(exp_rx.size()), 64'd0);

      // 7: go+abort together in IDLE (go wins), then synchronous reset
      clr();
      cfg_frames = CW'(5);
      cmd_go = 1'b1;
      cmd_abort = 1'b1;
      tick();
      cmd_go = 1'b0;
      cmd_abort = 1'b0;
      tick();
      chk("t7_go_wins_busy", 64'(busy), 64'd1);
      chk("t7_go_wins_count", 64'(frames_left), 64'd5);
      sresetn = 1'b0;
      tick();
      chk("t7_srst_busy", 64'(busy), 64'd0);
      chk("t7_srst_frames_left", 64'(frames_left), 64'd0);
      sresetn = 1'b1;
      tick();
      chk("t7_no_flush", 64'(n_flush), 64'd0);
      chk("t7_no_done", 64'(n_done), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
